// File: rtl/fan_timer_multistage.sv
//==============================================================================
// Module      : fan_timer_multistage
// Description : Multi-stage fan off-timer. A button steps through the stages.
//               Stage 0 runs continuously. Each other stage loads a BCD mm:ss
//               preset and counts it down once per second, with pause/resume.
//               When the count expires, fan_en drops.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fan_timer_multistage #(
    parameter int                            NUM_STAGES  = 4,
    parameter int                            TICK_CYCLES = 100_000_000,
    parameter logic [(NUM_STAGES-1)*16-1:0]  PRESETS     = {16'h0005, 16'h0004, 16'h0003}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run_en,
    input  logic                  btn_next,
    input  logic                  btn_pause,
    output logic [15:0]           value_timer,
    output logic                  fan_en,
    output logic                  expire,
    output logic                  paused,
    output logic [NUM_STAGES-2:0] stage_led
);

    localparam int c_stage_w = $clog2(NUM_STAGES);
    localparam int c_presc_w = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_presc_w-1:0] c_tick_max   = c_presc_w'(TICK_CYCLES - 1);
    localparam logic [c_stage_w-1:0] c_last_stage = c_stage_w'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [c_stage_w-1:0]    stage_q, stage_d;
    logic [15:0]             count_q, count_d;
    logic [c_presc_w-1:0]    presc_q, presc_d;
    logic                    expire_q, expire_d;
    logic                    fan_en_q, fan_en_d;
    logic                    paused_q, paused_d;
    logic [NUM_STAGES-2:0]   led_q, led_d;

    logic [c_stage_w-1:0]    stage_nxt;
    logic [15:0]             preset_sel;
    logic                    tick;

    // BCD mm:ss decrement with borrow; only applied to a non-zero count.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Next stage on a button press and the preset that stage would load.
    always_comb begin
        stage_nxt  = (stage_q == c_last_stage) ? '0 : stage_q + c_stage_w'(1);
        preset_sel = 16'h0000;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (stage_nxt == c_stage_w'(k)) begin
                preset_sel = PRESETS[(k-1)*16 +: 16];
            end
        end
    end

    // Timer FSM: priority is run_en low, then btn_next, then per-state behaviour.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        count_d  = count_q;
        presc_d  = presc_q;
        expire_d = 1'b0;
        tick     = (presc_q == c_tick_max);

        if (!run_en) begin
            state_d = S_IDLE;
            stage_d = '0;
            count_d = 16'h0000;
            presc_d = '0;
        end else if (btn_next) begin
            // A load discards any tick due in the same cycle.
            stage_d = stage_nxt;
            presc_d = '0;
            if (stage_nxt == '0) begin
                state_d = S_IDLE;
                count_d = 16'h0000;
            end else begin
                state_d = S_RUN;
                count_d = preset_sel;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                end
                S_RUN: begin
                    if (count_q == 16'h0000) begin
                        // Only reachable through a zero preset.
                        state_d  = S_EXPIRED;
                        expire_d = 1'b1;
                        presc_d  = '0;
                    end else begin
                        presc_d = tick ? '0 : presc_q + c_presc_w'(1);
                        if (tick) begin
                            count_d = bcd_dec(count_q);
                            if (count_q == 16'h0001) begin
                                state_d  = S_EXPIRED;
                                expire_d = 1'b1;
                            end
                        end
                        if (btn_pause && state_d == S_RUN) begin
                            state_d = S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (btn_pause) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    count_d = 16'h0000;
                    presc_d = '0;
                end
            endcase
        end

        fan_en_d = (state_d != S_EXPIRED);
        paused_d = (state_d == S_PAUSE);
        led_d    = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            led_d[k-1] = (stage_d == c_stage_w'(k));
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            stage_q  <= '0;
            count_q  <= 16'h0000;
            presc_q  <= '0;
            expire_q <= 1'b0;
            fan_en_q <= 1'b1;
            paused_q <= 1'b0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            expire_q <= expire_d;
            fan_en_q <= fan_en_d;
            paused_q <= paused_d;
            led_q    <= led_d;
        end
    end

    assign value_timer = count_q;
    assign fan_en      = fan_en_q;
    assign expire      = expire_q;
    assign paused      = paused_q;
    assign stage_led   = led_q;

endmodule

`default_nettype wire

// File: tb/tb_fan_timer_multistage.sv
//==============================================================================
// Module      : tb_fan_timer_multistage
// Description : Bench for fan_timer_multistage. Two instances share stimulus:
//               dut_a uses the default presets and dut_b uses 0100/1000/0000.
//               A seconds-based model of each instance is compared every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fan_timer_multistage;

    localparam int          NS    = 4;
    localparam int          TICK  = 10;
    localparam logic [47:0] PRE_A = {16'h0005, 16'h0004, 16'h0003};
    localparam logic [47:0] PRE_B = {16'h0000, 16'h1000, 16'h0100};

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic run_en    = 1'b0;
    logic btn_next  = 1'b0;
    logic btn_pause = 1'b0;

    logic [15:0] a_val, b_val;
    logic        a_fan, b_fan, a_exp, b_exp, a_pau, b_pau;
    logic [2:0]  a_led, b_led;

    int n_tests = 0;
    int n_fail  = 0;

    fan_timer_multistage #(.NUM_STAGES(NS), .TICK_CYCLES(TICK), .PRESETS(PRE_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .run_en(run_en), .btn_next(btn_next),
        .btn_pause(btn_pause), .value_timer(a_val), .fan_en(a_fan), .expire(a_exp),
        .paused(a_pau), .stage_led(a_led)
    );

    fan_timer_multistage #(.NUM_STAGES(NS), .TICK_CYCLES(TICK), .PRESETS(PRE_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .run_en(run_en), .btn_next(btn_next),
        .btn_pause(btn_pause), .value_timer(b_val), .fan_en(b_fan), .expire(b_exp),
        .paused(b_pau), .stage_led(b_led)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (remaining time kept in seconds) ----
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    typedef struct {
        int mode;
        int stage;
        int secs;
        int phase;
        bit exp;
    } model_t;

    model_t ma, mb;
    bit     started = 1'b0;

    function automatic int bcd2sec(logic [15:0] b);
        int mn, sc;
        mn = int'(b[15:12]) * 10 + int'(b[11:8]);
        sc = int'(b[7:4]) * 10 + int'(b[3:0]);
        return mn * 60 + sc;
    endfunction

    function automatic logic [15:0] sec2bcd(int s);
        int mn, sc;
        mn = s / 60;
        sc = s % 60;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic model_t step(model_t m, logic rn, logic re, logic nx, logic pa,
                                    logic [47:0] pre);
        model_t n;
        n     = m;
        n.exp = 1'b0;
        if (!rn || !re) begin
            n.mode = M_IDLE; n.stage = 0; n.secs = 0; n.phase = 0;
        end else if (nx) begin
            n.stage = (m.stage + 1) % NS;
            n.phase = 0;
            if (n.stage == 0) begin
                n.mode = M_IDLE; n.secs = 0;
            end else begin
                n.mode = M_RUN;
                n.secs = bcd2sec(pre[(n.stage-1)*16 +: 16]);
            end
        end else begin
            case (m.mode)
                M_IDLE: n.phase = 0;
                M_RUN: begin
                    if (m.secs == 0) begin
                        n.mode = M_EXP; n.exp = 1'b1; n.phase = 0;
                    end else begin
                        n.phase = (m.phase + 1) % TICK;
                        if (m.phase == TICK - 1) begin
                            n.secs = m.secs - 1;
                            if (n.secs == 0) begin
                                n.mode = M_EXP; n.exp = 1'b1;
                            end
                        end
                        if (pa && n.mode == M_RUN) n.mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (pa) n.mode = M_RUN;
                default: begin n.secs = 0; n.phase = 0; end
            endcase
        end
        return n;
    endfunction

    // Advance both models on every active edge from the sampled inputs.
    always @(posedge clk) begin
        ma = step(ma, reset_n, run_en, btn_next, btn_pause, PRE_A);
        mb = step(mb, reset_n, run_en, btn_next, btn_pause, PRE_B);
        started = 1'b1;
    end

    task automatic check_model(string nm, logic [15:0] v, logic f, logic e, logic p,
                               logic [2:0] l, model_t m);
        logic [15:0] ev;
        logic [2:0]  el;
        ev = sec2bcd(m.secs);
        el = (m.stage == 0) ? 3'b000 : 3'(1 << (m.stage - 1));
        n_tests++;
        if ({v, f, e, p, l} !== {ev, (m.mode != M_EXP), m.exp, (m.mode == M_PAUSE), el}) begin
            n_fail++;
            $display("FAIL model_%s @%0t: got val=%h fan_en=%b expire=%b paused=%b led=%b, want val=%h fan_en=%b expire=%b paused=%b led=%b",
                     nm, $time, v, f, e, p, l, ev, (m.mode != M_EXP), m.exp, (m.mode == M_PAUSE), el);
        end
    endtask

    // Compare both DUTs against their models away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check_model("a", a_val, a_fan, a_exp, a_pau, a_led, ma);
            check_model("b", b_val, b_fan, b_exp, b_pau, b_led, mb);
        end
    end

    // ---------------- directed stimulus with literal expectations ----------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, want);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_next();
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
    endtask

    task automatic pulse_pause();
        btn_pause = 1'b1;
        @(negedge clk);
        btn_pause = 1'b0;
    endtask

    initial begin
        // Reset values
        cyc(2);
        chk("rst_val",    32'(a_val), 32'h0000);
        chk("rst_led",    32'(a_led), 32'h0);
        chk("rst_fan_en", 32'(a_fan), 32'h1);
        chk("rst_expire", 32'(a_exp), 32'h0);
        chk("rst_paused", 32'(a_pau), 32'h0);
        reset_n = 1'b1;
        run_en  = 1'b1;
        cyc(2);

        // Stage 1 countdown to expiry; dut_b shows 0100 -> 0059
        pulse_next();
        chk("t1_load_val", 32'(a_val), 32'h0003);
        chk("t1_load_led", 32'(a_led), 32'h1);
        cyc(10);
        chk("t1_tick_a",   32'(a_val), 32'h0002);
        chk("t1_tick_b",   32'(b_val), 32'h0059);
        cyc(19);
        chk("t1_pre_val",  32'(a_val), 32'h0001);
        chk("t1_pre_fan",  32'(a_fan), 32'h1);
        cyc(1);
        chk("t1_exp_val",  32'(a_val), 32'h0000);
        chk("t1_exp_pls",  32'(a_exp), 32'h1);
        chk("t1_exp_fan",  32'(a_fan), 32'h0);
        chk("t1_b_val",    32'(b_val), 32'h0057);
        cyc(1);
        chk("t1_exp_once", 32'(a_exp), 32'h0);
        chk("t1_exp_hold", 32'(a_fan), 32'h0);
        chk("t1_exp_led",  32'(a_led), 32'h1);

        // Walk stages 2, 3, then wrap to 0; dut_b 1000 -> 0959, zero preset
        pulse_next();
        chk("t2_s2_val",   32'(a_val), 32'h0004);
        chk("t2_s2_led",   32'(a_led), 32'h2);
        chk("t2_s2_fan",   32'(a_fan), 32'h1);
        chk("t2_b_load",   32'(b_val), 32'h1000);
        cyc(10);
        chk("t2_b_tick",   32'(b_val), 32'h0959);
        pulse_next();
        chk("t2_s3_val",   32'(a_val), 32'h0005);
        chk("t2_s3_led",   32'(a_led), 32'h4);
        chk("t2_b0_noexp", 32'(b_exp), 32'h0);
        cyc(1);
        chk("t2_b0_exp",   32'(b_exp), 32'h1);
        chk("t2_b0_fan",   32'(b_fan), 32'h0);
        pulse_next();
        chk("t2_s0_led",   32'(a_led), 32'h0);
        chk("t2_s0_val",   32'(a_val), 32'h0000);
        chk("t2_s0_fan",   32'(a_fan), 32'h1);
        chk("t2_s0_exp",   32'(a_exp), 32'h0);

        // Pause in stage 1: expiry after exactly 30 RUN cycles
        pulse_next();
        cyc(4);
        pulse_pause();
        chk("t3_paused",   32'(a_pau), 32'h1);
        cyc(25);
        chk("t3_hold_val", 32'(a_val), 32'h0003);
        chk("t3_hold_pau", 32'(a_pau), 32'h1);
        pulse_pause();
        chk("t3_resume",   32'(a_pau), 32'h0);
        cyc(24);
        chk("t3_pre_val",  32'(a_val), 32'h0001);
        cyc(1);
        chk("t3_exp_val",  32'(a_val), 32'h0000);
        chk("t3_exp_pls",  32'(a_exp), 32'h1);

        // run_en drop mid-count; buttons ignored while low
        pulse_next();
        cyc(20);
        chk("t5_mid_val",  32'(a_val), 32'h0002);
        run_en    = 1'b0;
        btn_next  = 1'b1;
        btn_pause = 1'b1;
        cyc(1);
        chk("t5_idle_val", 32'(a_val), 32'h0000);
        chk("t5_idle_led", 32'(a_led), 32'h0);
        chk("t5_idle_fan", 32'(a_fan), 32'h1);
        cyc(2);
        chk("t5_ign_led",  32'(a_led), 32'h0);
        chk("t5_ign_pau",  32'(a_pau), 32'h0);
        btn_next  = 1'b0;
        btn_pause = 1'b0;
        run_en    = 1'b1;
        cyc(1);
        pulse_next();
        chk("t5_restart",  32'(a_led), 32'h1);

        // btn_next + btn_pause together: next wins
        cyc(2);
        btn_next  = 1'b1;
        btn_pause = 1'b1;
        cyc(1);
        btn_next  = 1'b0;
        btn_pause = 1'b0;
        chk("t6_both_led", 32'(a_led), 32'h2);
        chk("t6_both_val", 32'(a_val), 32'h0004);
        chk("t6_both_pau", 32'(a_pau), 32'h0);

        // Reset mid-RUN
        cyc(3);
        reset_n = 1'b0;
        cyc(1);
        chk("t6_rst_val",  32'(a_val), 32'h0000);
        chk("t6_rst_led",  32'(a_led), 32'h0);
        chk("t6_rst_fan",  32'(a_fan), 32'h1);
        chk("t6_rst_bval", 32'(b_val), 32'h0000);
        reset_n = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
